// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the configurable UART transmitter.
//   - PARITY_* : encodings of the PARITY parameter
//   - state_t  : transmitter FSM state encoding
//   - baud_div : clocks per bit, rounded to the nearest integer
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: upstream write handshake into the UART transmitter.
//   tx_data  : word to send (DATA_BITS wide)
//   tx_valid : tx_data valid
//   tx_ready : transmitter FIFO can accept; a push is tx_valid & tx_ready
// master = upstream producer, slave = uart_tx_cfg.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/uart_fifo_sync.sv
// uart_fifo_sync: single-clock FIFO, DEPTH a power of two.
//   clk, rst  : clock, async active-high reset (empties the FIFO)
//   push      : write push_data (ignored when full)
//   pop       : drop the head word (ignored when empty)
//   pop_data  : current head word, valid while !empty
//   full/empty: status flags
//   level     : words held, 0..DEPTH
// Pointers carry one extra MSB so full and empty are distinguishable.
module uart_fifo_sync #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are meaningful, and leaving it unreset keeps it plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with baud divider and TX FIFO.
//   clk        : system clock, rising edge
//   rst        : async active-high reset; aborts any frame, empties the FIFO
//   bus        : uart_tx_cfg_if.slave write handshake (tx_data/tx_valid/tx_ready)
//   tx_busy    : frame in progress or FIFO non-empty
//   fifo_level : words currently held in the FIFO
//   txd        : serial line, idle high, driven straight from a flop
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// Each bit lasts DIV clocks; queued frames follow each other with no idle gap.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  uart_tx_cfg_if.slave                    bus,
  output logic                            tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            txd
);

  localparam int              DIV       = baud_div(CLK_HZ, BAUD);
  localparam int              CNT_W     = $clog2(DIV);
  localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: clocks per bit must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
  end

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == PARITY_ODD) ? ~^d : ^d;
  endfunction

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shifter;
  logic                 parity_bit;

  logic [DATA_BITS-1:0] head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 frame_end;

  assign bit_end   = (baud_cnt == '0);
  assign frame_end = (state == ST_STOP) && bit_end && (bit_cnt == STOP_LAST);
  // A word is taken either from idle or right at the end of the last stop bit,
  // which is what makes queued frames run back-to-back.
  assign pop  = ~fifo_empty & ((state == ST_IDLE) | frame_end);
  assign push = bus.tx_valid & bus.tx_ready;

  assign bus.tx_ready = ~fifo_full;
  assign tx_busy      = (state != ST_IDLE) | ~fifo_empty;

  uart_fifo_sync #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.tx_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // NOTE: all state here uses non-blocking assignments, so every branch reads
  // the pre-edge values and later assignments (the pop load below) simply win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      parity_bit <= 1'b0;
      txd        <= 1'b1;
    end else begin
      if (!bit_end) baud_cnt <= baud_cnt - 1'b1;

      case (state)
        ST_IDLE: txd <= 1'b1;

        ST_START: begin
          if (bit_end) begin
            baud_cnt <= DIV_M1;
            txd      <= shifter[0];
            shifter  <= shifter >> 1;
            bit_cnt  <= '0;
            state    <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= DIV_M1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                txd   <= parity_bit;
                state <= ST_PARITY;
              end else begin
                txd   <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              txd     <= shifter[0];
              shifter <= shifter >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            baud_cnt <= DIV_M1;
            txd      <= 1'b1;
            bit_cnt  <= '0;
            state    <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= DIV_M1;
            if (bit_cnt == STOP_LAST) state <= ST_IDLE;
            else                      bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          txd   <= 1'b1;
        end
      endcase

      // Frame start: overrides the IDLE/STOP handling above. The baud counter
      // restarts here, so bit timing is always relative to the frame start.
      if (pop) begin
        shifter    <= head;
        parity_bit <= calc_parity(head);
        baud_cnt   <= DIV_M1;
        txd        <= 1'b0;
        state      <= ST_START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: three instances (8N1, 7E2, 8O1) at
// CLK_HZ=1_000_000, BAUD=100_000, i.e. 10 clocks per bit.
module tb_uart_tx_cfg;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if_b ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_c ();

  logic       busy_a, busy_b, busy_c;
  logic [2:0] lvl_a, lvl_b, lvl_c;
  logic       txd_a, txd_b, txd_c;

  uart_tx_cfg #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .tx_busy(busy_a), .fifo_level(lvl_a), .txd(txd_a));

  uart_tx_cfg #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .tx_busy(busy_b), .fifo_level(lvl_b), .txd(txd_b));

  uart_tx_cfg #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1),
                .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c), .tx_busy(busy_c), .fifo_level(lvl_c), .txd(txd_c));

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic line(input int d);
    case (d)
      0:       return txd_a;
      1:       return txd_b;
      default: return txd_c;
    endcase
  endfunction

  function automatic logic busy(input int d);
    case (d)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Observes nbits bit periods starting at the next edge. mid[b] is the line
  // value mid-bit; glitches counts cycles where the line differs from the
  // first cycle of its bit (catches misaligned or wrong-length bits).
  task automatic sample_frame(input int d, input int nbits, output logic [15:0] mid,
                              output int glitches, output int busy_low);
    logic first;
    mid      = '0;
    glitches = 0;
    busy_low = 0;
    first    = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < DIV; c++) begin
        tick();
        if (c == 0) first = line(d);
        else if (line(d) !== first) glitches++;
        if (c == DIV / 2) mid[b] = line(d);
        if (busy(d) !== 1'b1) busy_low++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_a.tx_valid = 1'b0; if_a.tx_data = '0;
    if_b.tx_valid = 1'b0; if_b.tx_data = '0;
    if_c.tx_valid = 1'b0; if_c.tx_data = '0;
    #2;
    checks++;
    if ({txd_a, txd_b, txd_c} !== 3'b111) begin
      errors++; $display("FAIL reset_txd got %b exp 111", {txd_a, txd_b, txd_c});
    end
    checks++;
    if ({busy_a, busy_b, busy_c} !== 3'b000) begin
      errors++; $display("FAIL reset_busy got %b exp 000", {busy_a, busy_b, busy_c});
    end
    checks++;
    if ({lvl_a, lvl_b, lvl_c} !== 9'd0) begin
      errors++; $display("FAIL reset_level got %0d/%0d/%0d exp 0", lvl_a, lvl_b, lvl_c);
    end
    checks++;
    if ({if_a.tx_ready, if_b.tx_ready, if_c.tx_ready} !== 3'b111) begin
      errors++; $display("FAIL reset_ready got %b exp 111",
                         {if_a.tx_ready, if_b.tx_ready, if_c.tx_ready});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_8n1();
    logic [15:0] mid;
    int          gl, bl;
    if_a.tx_data  = 8'h45;
    if_a.tx_valid = 1'b1;
    tick();
    if_a.tx_valid = 1'b0;
    checks++;
    if (lvl_a !== 3'd1 || txd_a !== 1'b1) begin
      errors++; $display("FAIL 8n1_after_push level %0d txd %b exp 1 1", lvl_a, txd_a);
    end
    sample_frame(0, 10, mid, gl, bl);
    checks++;
    if (mid[9:0] !== {1'b1, 8'h45, 1'b0}) begin
      errors++; $display("FAIL 8n1_frame got %h exp %h", mid[9:0], {1'b1, 8'h45, 1'b0});
    end
    checks++;
    if (gl !== 0) begin
      errors++; $display("FAIL 8n1_bit_timing got %0d glitches exp 0", gl);
    end
    checks++;
    if (bl !== 0) begin
      errors++; $display("FAIL 8n1_busy_during_frame got %0d low cycles exp 0", bl);
    end
    tick();
    checks++;
    if (busy_a !== 1'b0 || txd_a !== 1'b1) begin
      errors++; $display("FAIL 8n1_end busy %b txd %b exp 0 1", busy_a, txd_a);
    end
  endtask

  task automatic test_7e2();
    logic [15:0] mid;
    int          gl, bl;
    if_b.tx_data  = 7'h55;
    if_b.tx_valid = 1'b1;
    tick();
    if_b.tx_valid = 1'b0;
    sample_frame(1, 11, mid, gl, bl);
    checks++;
    if (mid[10:0] !== {2'b11, 1'b0, 7'h55, 1'b0}) begin
      errors++; $display("FAIL 7e2_frame got %h exp %h", mid[10:0], {2'b11, 1'b0, 7'h55, 1'b0});
    end
    checks++;
    if (gl !== 0 || bl !== 0) begin
      errors++; $display("FAIL 7e2_timing glitches %0d busy_low %0d exp 0 0", gl, bl);
    end
    tick();
    checks++;
    if (busy_b !== 1'b0 || txd_b !== 1'b1) begin
      errors++; $display("FAIL 7e2_end busy %b txd %b exp 0 1", busy_b, txd_b);
    end
  endtask

  task automatic test_8o1_parity();
    logic [15:0] mid0, mid1;
    int          gl0, bl0, gl1, bl1;
    fork
      begin
        if_c.tx_data  = 8'h00;
        if_c.tx_valid = 1'b1;
        tick();
        if_c.tx_data  = 8'h01;
        tick();
        if_c.tx_valid = 1'b0;
      end
      begin
        tick();
        sample_frame(2, 11, mid0, gl0, bl0);
        sample_frame(2, 11, mid1, gl1, bl1);
      end
    join
    checks++;
    if (mid0[10:0] !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      errors++; $display("FAIL 8o1_frame_00 got %h exp %h", mid0[10:0], {1'b1, 1'b1, 8'h00, 1'b0});
    end
    checks++;
    if (mid1[10:0] !== {1'b1, 1'b0, 8'h01, 1'b0}) begin
      errors++; $display("FAIL 8o1_frame_01 got %h exp %h", mid1[10:0], {1'b1, 1'b0, 8'h01, 1'b0});
    end
    checks++;
    if (gl0 + gl1 + bl0 + bl1 !== 0) begin
      errors++; $display("FAIL 8o1_timing got %0d bad cycles exp 0", gl0 + gl1 + bl0 + bl1);
    end
    tick();
    checks++;
    if (busy_c !== 1'b0) begin
      errors++; $display("FAIL 8o1_end busy got %b exp 0", busy_c);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] mid;
    int          gl, bl;
    int          exp_lvl [6] = '{1, 1, 2, 3, 4, 4};
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if_a.tx_data  = 8'(i + 1);
          if_a.tx_valid = 1'b1;
          tick();
          checks++;
          if (lvl_a !== 3'(exp_lvl[i])) begin
            errors++; $display("FAIL overflow_level[%0d] got %0d exp %0d", i, lvl_a, exp_lvl[i]);
          end
          if (i == 4) begin
            checks++;
            if (if_a.tx_ready !== 1'b0) begin
              errors++; $display("FAIL overflow_ready got %b exp 0", if_a.tx_ready);
            end
          end
        end
        if_a.tx_valid = 1'b0;
      end
      begin
        tick();
        for (int f = 0; f < 5; f++) begin
          sample_frame(0, 10, mid, gl, bl);
          checks++;
          if (mid[9:0] !== {1'b1, 8'(f + 1), 1'b0} || gl !== 0 || bl !== 0) begin
            errors++; $display("FAIL overflow_frame[%0d] got %h glitches %0d exp %h 0",
                               f, mid[9:0], gl, {1'b1, 8'(f + 1), 1'b0});
          end
        end
      end
    join
    tick();
    checks++;
    if (busy_a !== 1'b0 || txd_a !== 1'b1) begin
      errors++; $display("FAIL overflow_dropped busy %b txd %b exp 0 1", busy_a, txd_a);
    end
  endtask

  task automatic test_same_edge();
    logic [15:0] mid;
    int          gl, bl;
    logic [7:0]  words [4] = '{8'hA5, 8'h3C, 8'h0F, 8'hE1};
    fork
      begin
        if_a.tx_data  = words[0];
        if_a.tx_valid = 1'b1;
        tick();
        if_a.tx_data  = words[1];
        tick();
        if_a.tx_data  = words[2];
        tick();
        if_a.tx_valid = 1'b0;
        checks++;
        if (lvl_a !== 3'd2) begin
          errors++; $display("FAIL same_edge_pre got %0d exp 2", lvl_a);
        end
        repeat (98) tick();
        checks++;
        if (lvl_a !== 3'd2) begin
          errors++; $display("FAIL same_edge_before got %0d exp 2", lvl_a);
        end
        if_a.tx_data  = words[3];
        if_a.tx_valid = 1'b1;
        tick();
        if_a.tx_valid = 1'b0;
        checks++;
        if (lvl_a !== 3'd2) begin
          errors++; $display("FAIL same_edge_after got %0d exp 2", lvl_a);
        end
      end
      begin
        tick();
        for (int f = 0; f < 4; f++) begin
          sample_frame(0, 10, mid, gl, bl);
          checks++;
          if (mid[9:0] !== {1'b1, words[f], 1'b0} || gl !== 0) begin
            errors++; $display("FAIL same_edge_frame[%0d] got %h glitches %0d exp %h 0",
                               f, mid[9:0], gl, {1'b1, words[f], 1'b0});
          end
        end
      end
    join
    tick();
    checks++;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL same_edge_end busy got %b exp 0", busy_a);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] mid;
    int          gl, bl;
    int          idle_bad;
    if_a.tx_data  = 8'h45;
    if_a.tx_valid = 1'b1;
    tick();
    if_a.tx_data  = 8'h99;
    tick();
    if_a.tx_valid = 1'b0;
    repeat (44) tick();
    // Now in the middle of data bit 3 of 0x45 (a zero), one word queued.
    checks++;
    if (txd_a !== 1'b0 || lvl_a !== 3'd1) begin
      errors++; $display("FAIL rst_mid_setup txd %b level %0d exp 0 1", txd_a, lvl_a);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (txd_a !== 1'b1 || lvl_a !== 3'd0) begin
      errors++; $display("FAIL rst_mid_async txd %b level %0d exp 1 0", txd_a, lvl_a);
    end
    checks++;
    if (busy_a !== 1'b0 || if_a.tx_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_status busy %b ready %b exp 0 1", busy_a, if_a.tx_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (txd_a !== 1'b1 || busy_a !== 1'b0) idle_bad++;
    end
    checks++;
    if (idle_bad !== 0) begin
      errors++; $display("FAIL rst_mid_idle got %0d non-idle cycles exp 0", idle_bad);
    end
    if_a.tx_data  = 8'h3A;
    if_a.tx_valid = 1'b1;
    tick();
    if_a.tx_valid = 1'b0;
    sample_frame(0, 10, mid, gl, bl);
    checks++;
    if (mid[9:0] !== {1'b1, 8'h3A, 1'b0} || gl !== 0 || bl !== 0) begin
      errors++; $display("FAIL rst_mid_new_frame got %h glitches %0d exp %h 0",
                         mid[9:0], gl, {1'b1, 8'h3A, 1'b0});
    end
    tick();
    checks++;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL rst_mid_end busy got %b exp 0", busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e2();
    test_8o1_parity();
    test_overflow();
    test_same_edge();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
